fp_addsub_sched: RTL and testbench
==================================

Name: fp_addsub_sched

Overview:
- Shares one single-precision add datapath and one single-precision subtract datapath between NREQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Drives the shared units, waits UNIT_LAT cycles, then returns the result with the requester ID over a valid/ready response channel.
- Sits between the client blocks and the combinational FP add/sub units. Only one operation is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- UNIT_LAT, 1, cycles from operand drive to result capture (1..15; >1 covers pipelined units).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_sub  in  NREQ  per-requester op select: 1 = a-b (subtract unit), 0 = a+b (add unit).
- req_a  in  32*NREQ  operand a; requester i uses bits [32i+31:32i].
- req_b  in  32*NREQ  operand b; same packing as req_a.
- unit_a  out  32  operand a to both shared units.
- unit_b  out  32  operand b to both shared units.
- unit_sub  out  1  selects which unit result is expected (drives the result mux outside).
- unit_result  in  32  result from the selected unit.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- rsp_data  out  32  IEEE-754 single result, forwarded verbatim from unit_result.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed responses, wraps at 0xFFFF -> 0.

Behaviour:
- Reset, synchronous and applied on the clk edge:
  - state=IDLE, last_grant=NREQ-1 (so requester 0 wins first).
  - All outputs 0: req_ready, rsp_valid, rsp_id, rsp_data, unit_a, unit_b, unit_sub, busy, op_count.
  - Operand registers cleared.
  - Reset mid-operation discards the in-flight op; no response is produced for it.
- State machine, three states:
  - IDLE:
    - If any req_valid: winner g is the first asserted index after last_grant, searching upward modulo NREQ.
    - req_ready[g]=1 combinationally in this cycle only.
    - On the clock edge: latch req_a/req_b/req_sub of g and store g; wait_cnt=UNIT_LAT; go to WAIT.
    - No req_valid: stay in IDLE, req_ready=0.
  - WAIT:
    - unit_a/unit_b/unit_sub are driven from the operand registers, stable for the whole state.
    - wait_cnt decrements each cycle.
    - In the cycle wait_cnt==1: capture unit_result into rsp_data, rsp_id=g; go to RESP.
    - WAIT lasts exactly UNIT_LAT cycles.
  - RESP:
    - rsp_valid=1; rsp_data and rsp_id held stable.
    - On rsp_valid & rsp_ready: last_grant=g, op_count+=1, go to IDLE.
    - Otherwise hold indefinitely; req_ready stays 0.
- Timing:
  - Latency: accept at cycle T -> rsp_valid first high at T+UNIT_LAT+1.
  - Minimum issue interval: UNIT_LAT+2 cycles.
- req_ready is 0 outside IDLE, and 0 for every non-winner.
- Requester obligation: hold req_valid and operands until req_ready. A requester deasserting req_valid early loses only that cycle's arbitration.
- unit_a/unit_b/unit_sub hold their last values in IDLE and RESP; they are not zeroed.
- Data handling: no FP interpretation in this block. Special values (zero, denormal, inf, NaN) pass through untouched.
- Simultaneous events:
  - A requester asserting req_valid in the same cycle as the RESP handshake is considered only in the following IDLE cycle.
  - op_count 0xFFFF + 1 -> 0x0000.
- NREQ=1 degenerates to always granting requester 0.

Test Plan:
- Single add: requester 1 issues req_sub=0, a=0x40400000 (3.0), b=0x3F800000 (1.0), UNIT_LAT=1, rsp_ready=1, real units attached.
  -> req_ready[1] at T; rsp_valid at T+2 with rsp_data=0x40800000, rsp_id=1; op_count=1.
- Single subtract: requester 2 issues req_sub=1, same operands.
  -> unit_sub=1 during WAIT; rsp_data=0x40000000 (2.0), rsp_id=2.
- Round-robin: all four req_valid held high, each with distinct operands.
  -> grants in order 0,1,2,3,0; each rsp_id matches; grants spaced exactly UNIT_LAT+2 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles in RESP while requesters are valid.
  -> rsp_valid, rsp_data and rsp_id stable; req_ready=0 throughout; completes on the cycle rsp_ready rises.
- Latency parameter: UNIT_LAT=4; bench stub returns 0xDEADBEEF only after 4 cycles of stable operands.
  -> rsp_valid at T+5 with rsp_data=0xDEADBEEF; unit_a/unit_b constant over all 4 WAIT cycles.
- Reset mid-op: assert rst for one cycle during WAIT after granting requester 2.
  -> next cycle: state IDLE, rsp_valid=0, op_count=0, busy=0; no response for the dropped op; next grant goes to requester 0.

Source files
------------

// File: rtl/fp_addsub_sched_if.sv
// Request/response channels between the client blocks and fp_addsub_sched.
// Requests are packed per requester; responses carry the owning requester index.
interface fp_addsub_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      req_sub;
   logic [32*NREQ-1:0]   req_a;
   logic [32*NREQ-1:0]   req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [31:0]          rsp_data;

   modport master (
      output req_valid, req_sub, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_sub, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one FP add and one FP subtract unit among NREQ
// requesters; one operation in flight, result returned after UNIT_LAT cycles.
module fp_addsub_sched #(
   parameter int NREQ     = 4,
   parameter int UNIT_LAT = 1,
   parameter int IDW      = 2
) (
   input  logic                clk,
   input  logic                rst,
   fp_addsub_sched_if.slave    bus,
   output logic [31:0]         unit_a,
   output logic [31:0]         unit_b,
   output logic                unit_sub,
   input  logic [31:0]         unit_result,
   output logic                busy,
   output logic [15:0]         op_count
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  last_grant_q, last_grant_d;
   logic [IDW-1:0]  owner_q, owner_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [3:0]      wait_cnt_q, wait_cnt_d;
   logic [31:0]     op_a_q, op_a_d;
   logic [31:0]     op_b_q, op_b_d;
   logic            op_sub_q, op_sub_d;
   logic [31:0]     rsp_data_q, rsp_data_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            busy_q, busy_d;
   logic [15:0]     op_count_q, op_count_d;

   logic            found;
   logic [IDW-1:0]  win;
   logic [NREQ-1:0] win_oh;
   logic [31:0]     win_a, win_b;
   logic            win_sub;

   // First pass takes the lowest valid index above last_grant; the second pass
   // wraps around to the lowest valid index overall.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no latch is inferred.
      found   = 1'b0;
      win     = '0;
      win_oh  = '0;
      win_a   = '0;
      win_b   = '0;
      win_sub = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && bus.req_valid[i] && (IDW'(i) > last_grant_q)) begin
            found     = 1'b1;
            win       = IDW'(i);
            win_oh    = '0;
            win_oh[i] = 1'b1;
            win_a     = bus.req_a[32*i +: 32];
            win_b     = bus.req_b[32*i +: 32];
            win_sub   = bus.req_sub[i];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && bus.req_valid[i]) begin
            found     = 1'b1;
            win       = IDW'(i);
            win_oh    = '0;
            win_oh[i] = 1'b1;
            win_a     = bus.req_a[32*i +: 32];
            win_b     = bus.req_b[32*i +: 32];
            win_sub   = bus.req_sub[i];
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE) ? win_oh : '0;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      rsp_id_d     = rsp_id_q;
      wait_cnt_d   = wait_cnt_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_sub_d     = op_sub_q;
      rsp_data_d   = rsp_data_q;
      op_count_d   = op_count_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               op_a_d     = win_a;
               op_b_d     = win_b;
               op_sub_d   = win_sub;
               owner_d    = win;
               wait_cnt_d = 4'(UNIT_LAT);
               state_d    = WAIT;
            end
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q - 4'd1;
            if (wait_cnt_q == 4'd1) begin
               rsp_data_d = unit_result;
               rsp_id_d   = owner_q;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               last_grant_d = owner_q;
               op_count_d   = op_count_q + 16'd1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      rsp_valid_d = (state_d == RESP);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NREQ - 1);
         owner_q      <= '0;
         rsp_id_q     <= '0;
         wait_cnt_q   <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_sub_q     <= 1'b0;
         rsp_data_q   <= '0;
         rsp_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         op_count_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         rsp_id_q     <= rsp_id_d;
         wait_cnt_q   <= wait_cnt_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_sub_q     <= op_sub_d;
         rsp_data_q   <= rsp_data_d;
         rsp_valid_q  <= rsp_valid_d;
         busy_q       <= busy_d;
         op_count_q   <= op_count_d;
      end
   end

   // Unit operands come straight from the operand registers, so they stay put
   // through IDLE and RESP until the next accept.
   assign unit_a       = op_a_q;
   assign unit_b       = op_b_q;
   assign unit_sub     = op_sub_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
   assign busy          = busy_q;
   assign op_count      = op_count_q;

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Self-checking bench for fp_addsub_sched: a transaction-level model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_fp_addsub_sched;
   localparam int NREQ = 4;
   localparam int LAT  = 4;
   localparam int IDW  = 2;
   localparam int W    = 32 * NREQ;
   localparam logic [31:0] F1 = 32'h3F800000;
   localparam logic [31:0] F3 = 32'h40400000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] unit_a, unit_b;
   logic        unit_sub;
   logic [31:0] unit_result = '0;
   logic        busy;
   logic [15:0] op_count;

   always #5 clk = ~clk;

   fp_addsub_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

   fp_addsub_sched #(.NREQ(NREQ), .UNIT_LAT(LAT), .IDW(IDW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .unit_a      (unit_a),
      .unit_b      (unit_b),
      .unit_sub    (unit_sub),
      .unit_result (unit_result),
      .busy        (busy),
      .op_count    (op_count)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
   endtask

   // Stand-in for the shared FP units: known pairs give true IEEE results, the
   // rest an integer fingerprint that still depends on every operand bit.
   function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b, input logic sub);
      if (a == F3 && b == F1) return sub ? 32'h40000000 : 32'h40800000;
      if (a == 32'h12345678 && b == 32'h9ABCDEF0) return 32'hDEADBEEF;
      return sub ? (a - b) : (a + b);
   endfunction

   function automatic bit bit_of(input logic [NREQ-1:0] v, input int r);
      logic [NREQ-1:0] s;
      s = v >> r;
      return s[0];
   endfunction

   // The result is only correct once the operands have been stable for LAT cycles.
   int          age = 0;
   logic [31:0] pa = '0, pb = '0;
   logic        ps = 1'b0;
   always @(negedge clk) begin
      if (unit_a !== pa || unit_b !== pb || unit_sub !== ps) age = 1;
      else if (age < 100) age++;
      pa = unit_a;
      pb = unit_b;
      ps = unit_sub;
      unit_result = (age >= LAT) ? unit_fn(unit_a, unit_b, unit_sub) : 32'hBAD0BAD0;
   end

   // Transaction-level model: one op in flight, accepted at cycle t_acc,
   // response visible from t_acc+LAT+1 until the handshake.
   bit             mvalid = 1'b0;
   bit             inflight = 1'b0;
   int             cyc = 0;
   int             t_acc = 0;
   int             mown = 0;
   int             lastg = NREQ - 1;
   logic [15:0]    mcount = '0;
   logic [31:0]    ma = '0, mb = '0;
   logic           msub = 1'b0;

   always @(negedge clk) begin : monitor
      int              g;
      int              idx;
      logic [NREQ-1:0] exp_rdy;
      logic [W-1:0]    sa, sb;
      bit              rv;
      cyc++;
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (lastg + k) % NREQ;
         if (g < 0 && bit_of(bus.req_valid, idx)) g = idx;
      end
      if (mvalid) begin
         exp_rdy = (!inflight && g >= 0) ? (NREQ'(1) << g) : '0;
         rv = inflight && (cyc >= t_acc + LAT + 1);
         check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
         check("busy", 32'(busy), 32'(inflight));
         check("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
         check("unit_a", unit_a, ma);
         check("unit_b", unit_b, mb);
         check("unit_sub", 32'(unit_sub), 32'(msub));
         check("op_count", 32'(op_count), 32'(mcount));
         if (rv) begin
            check("rsp_id", 32'(bus.rsp_id), 32'(mown));
            check("rsp_data", bus.rsp_data, unit_fn(ma, mb, msub));
         end
         if (rst) begin
            inflight = 1'b0;
            lastg    = NREQ - 1;
            mcount   = '0;
            ma = '0; mb = '0; msub = 1'b0;
         end else if (!inflight && g >= 0) begin
            inflight = 1'b1;
            t_acc    = cyc;
            mown     = g;
            sa = bus.req_a >> (32 * g);
            sb = bus.req_b >> (32 * g);
            ma = sa[31:0];
            mb = sb[31:0];
            msub = bit_of(bus.req_sub, g);
         end else if (rv && bus.rsp_ready) begin
            inflight = 1'b0;
            lastg    = mown;
            mcount   = mcount + 16'd1;
         end
      end else if (rst) begin
         mvalid = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input bit sub, input logic [31:0] a, input logic [31:0] b);
      logic [W-1:0] m;
      m = W'(32'hFFFFFFFF) << (32 * r);
      bus.req_a = (bus.req_a & ~m) | (W'(a) << (32 * r));
      bus.req_b = (bus.req_b & ~m) | (W'(b) << (32 * r));
      bus.req_valid = bus.req_valid | (NREQ'(1) << r);
      if (sub) bus.req_sub = bus.req_sub | (NREQ'(1) << r);
      else     bus.req_sub = bus.req_sub & ~(NREQ'(1) << r);
   endtask

   task automatic clr_req(input int r);
      bus.req_valid = bus.req_valid & ~(NREQ'(1) << r);
   endtask

   task automatic wait_ready(input string name, input int r);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         @(negedge clk);
         if (bit_of(bus.req_ready, r)) hit = 1'b1;
      end
      if (!hit) timeout(name);
   endtask

   task automatic wait_idle(input string name);
      bit hit;
      hit = 1'b0;
      for (int k = 0; k < 60 && !hit; k++) begin
         @(negedge clk);
         if (!busy) hit = 1'b1;
      end
      if (!hit) timeout(name);
   endtask

   // Starts at posedge+1, returns at the negedge of the first RESP cycle.
   task automatic directed_op(input string tag, input int r, input bit sub,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_data);
      int n;
      bit hit;
      set_req(r, sub, a, b);
      wait_ready({tag, "_grant"}, r);
      tick();
      clr_req(r);
      n = 0;
      hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(negedge clk);
         n++;
         if (bus.rsp_valid) hit = 1'b1;
         else begin
            check({tag, "_wait_a"}, unit_a, a);
            check({tag, "_wait_b"}, unit_b, b);
            check({tag, "_wait_sub"}, 32'(unit_sub), 32'(sub));
         end
      end
      if (!hit) timeout({tag, "_rsp"});
      check({tag, "_latency"}, 32'(n), 32'(LAT + 1));
      check({tag, "_data"}, bus.rsp_data, exp_data);
      check({tag, "_id"}, 32'(bus.rsp_id), 32'(r));
   endtask

   initial begin : main
      int          order[5];
      int          when[5];
      int          ng;
      int          n;
      logic [31:0] hold_data;
      logic [IDW-1:0] hold_id;
      logic [NREQ-1:0] hs;

      bus.req_valid = '0;
      bus.req_sub   = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
      check("rst_rsp_data", bus.rsp_data, 32'h0);
      check("rst_unit_a", unit_a, 32'h0);
      check("rst_unit_b", unit_b, 32'h0);
      check("rst_unit_sub", 32'(unit_sub), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_op_count", 32'(op_count), 32'h0);

      tick();
      bus.rsp_ready = 1'b1;
      directed_op("add", 1, 1'b0, F3, F1, 32'h40800000);
      @(negedge clk);
      check("add_op_count", 32'(op_count), 32'd1);
      tick();
      directed_op("sub", 2, 1'b1, F3, F1, 32'h40000000);
      @(negedge clk);
      check("sub_op_count", 32'(op_count), 32'd2);

      // Round-robin from reset: all four requesters held valid.
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int r = 0; r < NREQ; r++) set_req(r, r[0], 32'h1000 + 32'(r), 32'h20 * 32'(r + 1));
      ng = 0;
      n  = 0;
      for (int k = 0; k < 80 && ng < 5; k++) begin
         @(negedge clk);
         n++;
         for (int r = 0; r < NREQ; r++) begin
            if (bit_of(bus.req_ready, r) && ng < 5) begin
               order[ng] = r;
               when[ng]  = n;
               ng++;
            end
         end
         tick();
         if (ng > 0) set_req(order[ng-1], 1'b0, 32'h5000 + 32'(n), 32'h77 + 32'(n));
      end
      if (ng < 5) timeout("rr_grants");
      else begin
         check("rr_g0", 32'(order[0]), 32'd0);
         check("rr_g1", 32'(order[1]), 32'd1);
         check("rr_g2", 32'(order[2]), 32'd2);
         check("rr_g3", 32'(order[3]), 32'd3);
         check("rr_g4", 32'(order[4]), 32'd0);
         for (int i = 1; i < 5; i++) check("rr_spacing", 32'(when[i] - when[i-1]), 32'(LAT + 2));
      end
      bus.req_valid = '0;
      wait_idle("rr_drain");

      // Backpressure: response held for 5 cycles while others request.
      tick();
      bus.rsp_ready = 1'b0;
      set_req(0, 1'b0, 32'hCAFE0000, 32'h0000F00D);
      wait_ready("bp_grant", 0);
      tick();
      clr_req(0);
      set_req(1, 1'b1, 32'h11111111, 32'h2);
      set_req(2, 1'b0, 32'h33333333, 32'h4);
      set_req(3, 1'b1, 32'h55555555, 32'h6);
      n = 0;
      while (!bus.rsp_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rsp_valid) timeout("bp_rsp");
      hold_data = bus.rsp_data;
      hold_id   = bus.rsp_id;
      check("bp_data", hold_data, unit_fn(32'hCAFE0000, 32'h0000F00D, 1'b0));
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("bp_valid_hold", 32'(bus.rsp_valid), 32'd1);
         check("bp_data_hold", bus.rsp_data, hold_data);
         check("bp_id_hold", 32'(bus.rsp_id), 32'(hold_id));
         check("bp_no_ready", 32'(bus.req_ready), 32'h0);
      end
      tick();
      bus.rsp_ready = 1'b1;
      bus.req_valid = '0;
      @(negedge clk);
      check("bp_complete_valid", 32'(bus.rsp_valid), 32'd1);
      @(negedge clk);
      check("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
      check("bp_after_busy", 32'(busy), 32'd0);

      tick();
      directed_op("lat", 3, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF);

      // Reset during WAIT after granting requester 2.
      tick();
      set_req(2, 1'b1, 32'h0BADF00D, 32'h00C0FFEE);
      wait_ready("rst_mid_grant", 2);
      tick();
      clr_req(2);
      @(negedge clk);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rstmid_op_count", 32'(op_count), 32'd0);
      tick();
      for (int r = 0; r < NREQ; r++) set_req(r, 1'b0, 32'h42 + 32'(r), 32'h7);
      @(negedge clk);
      check("rstmid_next_grant", 32'(bus.req_ready), 32'h1);
      tick();
      bus.req_valid = '0;
      wait_idle("rstmid_drain");

      // Randomized traffic with random backpressure and occasional reset.
      hs = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         hs = bus.req_valid & bus.req_ready;
         tick();
         rst = ($urandom_range(0, 399) == 0);
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         for (int r = 0; r < NREQ; r++) begin
            if (bit_of(hs, r)) clr_req(r);
            else if (!bit_of(bus.req_valid, r) && $urandom_range(0, 2) == 0) begin
               if ($urandom_range(0, 7) == 0) set_req(r, 1'($urandom_range(0, 1)), F3, F1);
               else set_req(r, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
         end
      end
      rst = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
